// File: rtl/redmule_job_regfile_pkg.sv
// Shared types and address map for the RedMulE job register target.
// Holds the job FSM states, register offsets and descriptor view helpers.
package redmule_job_regfile_pkg;

    localparam int unsigned SYS_DATA_WIDTH = 32;
    localparam int unsigned NUM_CFG_REGS   = 6;

    localparam logic [31:0] REDMULE_TRIG_OFFS   = 32'h0000_0000;
    localparam logic [31:0] REDMULE_STATUS_OFFS = 32'h0000_0004;
    localparam logic [31:0] REDMULE_CFG_BASE    = 32'h0000_0040;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RUNNING = 2'd2
    } job_state_e;

    typedef struct packed {
        logic [31:0] x_ptr;
        logic [31:0] w_ptr;
        logic [31:0] z_ptr;
        logic [15:0] m;
        logic [15:0] k;
        logic [31:0] n;
        logic [31:0] arith;
    } redmule_job_t;

    // Word 3 carries K in the upper half and M in the lower half.
    function automatic redmule_job_t unpack_job(
        input logic [NUM_CFG_REGS*SYS_DATA_WIDTH-1:0] words
    );
        redmule_job_t job;
        job.x_ptr = words[0*SYS_DATA_WIDTH +: SYS_DATA_WIDTH];
        job.w_ptr = words[1*SYS_DATA_WIDTH +: SYS_DATA_WIDTH];
        job.z_ptr = words[2*SYS_DATA_WIDTH +: SYS_DATA_WIDTH];
        job.m     = words[3*SYS_DATA_WIDTH +: SYS_DATA_WIDTH/2];
        job.k     = words[3*SYS_DATA_WIDTH + SYS_DATA_WIDTH/2 +: SYS_DATA_WIDTH/2];
        job.n     = words[4*SYS_DATA_WIDTH +: SYS_DATA_WIDTH];
        job.arith = words[5*SYS_DATA_WIDTH +: SYS_DATA_WIDTH];
        return job;
    endfunction

    function automatic logic job_has_zero_dim(input redmule_job_t job);
        return (job.m == 16'd0) || (job.k == 16'd0) || (job.n == 32'd0);
    endfunction

endpackage

// File: rtl/redmule_job_regfile_if.sv
// Peripheral request/response bus between the RedMulE decoder and the job regfile.
interface redmule_job_regfile_if #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned SysDataWidth = 32,
    parameter int unsigned IdWidth      = 1
);
    logic                      req;
    logic                      gnt;
    logic [AddrWidth-1:0]      add;
    logic                      wen;
    logic [SysDataWidth/8-1:0] be;
    logic [SysDataWidth-1:0]   data;
    logic [IdWidth-1:0]        id;
    logic                      r_valid;
    logic [SysDataWidth-1:0]   r_data;
    logic [IdWidth-1:0]        r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_valid, r_data, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_valid, r_data, r_id
    );
endinterface

// File: rtl/redmule_job_regfile_staging.sv
// Byte-enabled staging bank for the next job's config words plus a per-word written mask.
module redmule_job_regfile_staging
    import redmule_job_regfile_pkg::*;
#(
    parameter int unsigned SysDataWidth = SYS_DATA_WIDTH,
    parameter int unsigned NumCfgRegs   = NUM_CFG_REGS,
    parameter int unsigned IdxWidth     = $clog2(NumCfgRegs)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               wr_en,
    input  logic [IdxWidth-1:0]                wr_idx,
    input  logic [SysDataWidth/8-1:0]          wr_be,
    input  logic [SysDataWidth-1:0]            wr_data,
    input  logic                               mask_clr,
    output logic [NumCfgRegs*SysDataWidth-1:0] words,
    output logic                               all_written
);
    localparam int unsigned NumBytes = SysDataWidth / 8;

    logic [SysDataWidth-1:0] word_r [NumCfgRegs];
    logic [NumCfgRegs-1:0]   mask_r;

    // Staging words and written mask; a write and a mask clear never coincide on the bus.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NumCfgRegs; i++) begin
                word_r[i] <= '0;
            end
            mask_r <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NumCfgRegs; i++) begin
                if (wr_idx == IdxWidth'(i)) begin
                    for (int b = 0; b < NumBytes; b++) begin
                        if (wr_be[b]) begin
                            word_r[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                    mask_r[i] <= 1'b1;
                end
            end
        end else if (mask_clr) begin
            mask_r <= '0;
        end
    end

    // Flatten the bank into the descriptor word order.
    always_comb begin
        words = '0;
        for (int i = 0; i < NumCfgRegs; i++) begin
            words[i*SysDataWidth +: SysDataWidth] = word_r[i];
        end
    end

    assign all_written = &mask_r;

endmodule

// File: rtl/redmule_job_regfile.sv
// RedMulE job register target: stages config writes, launches one descriptor per trigger,
// hands it to the engine with valid/ready and signals job completion.
module redmule_job_regfile
    import redmule_job_regfile_pkg::*;
#(
    parameter int unsigned SysDataWidth = SYS_DATA_WIDTH,
    parameter int unsigned NumCfgRegs   = NUM_CFG_REGS,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned IdWidth      = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    redmule_job_regfile_if.slave               periph,
    output logic                               cfg_complete_o,
    output logic                               job_valid_o,
    input  logic                               job_ready_i,
    output logic [NumCfgRegs*SysDataWidth-1:0] job_cfg_o,
    input  logic                               done_i,
    output logic                               evt_o,
    output logic                               busy_o
);
    localparam int unsigned IdxWidth  = $clog2(NumCfgRegs);
    localparam int unsigned WordWidth = AddrWidth - 2;
    localparam logic [WordWidth-1:0] TrigWord   = WordWidth'(REDMULE_TRIG_OFFS[31:2]);
    localparam logic [WordWidth-1:0] StatusWord = WordWidth'(REDMULE_STATUS_OFFS[31:2]);
    localparam logic [WordWidth-1:0] CfgFirst   = WordWidth'(REDMULE_CFG_BASE[31:2]);
    localparam logic [WordWidth-1:0] CfgEnd     = CfgFirst + WordWidth'(NumCfgRegs);

    job_state_e                       state_r, state_n;
    logic [WordWidth-1:0]             word_addr_s;
    logic [IdxWidth-1:0]              wr_idx_s;
    logic                             stage_wr_s, trig_s, launch_s, zero_dim_s, all_written_s;
    logic                             err_r, evt_r, r_valid_r, addr_unused_s;
    logic [SysDataWidth-1:0]          read_data_s, r_data_r;
    logic [IdWidth-1:0]               r_id_r;
    logic [NumCfgRegs*SysDataWidth-1:0] staged_s, job_r;

    assign word_addr_s   = periph.add[AddrWidth-1:2];
    assign addr_unused_s = ^periph.add[1:0];
    assign wr_idx_s      = IdxWidth'(word_addr_s - CfgFirst);
    assign stage_wr_s    = periph.req && !periph.wen &&
                           (word_addr_s >= CfgFirst) && (word_addr_s < CfgEnd);

    // Staging writes stall while a descriptor waits for the engine so it cannot change under it.
    always_comb begin
        periph.gnt = periph.req;
        if (stage_wr_s && (state_r == PENDING)) begin
            periph.gnt = 1'b0;
        end else begin
            periph.gnt = periph.req;
        end
    end

    assign trig_s         = periph.gnt && !periph.wen && (word_addr_s == TrigWord);
    assign cfg_complete_o = all_written_s && (state_r == IDLE);
    assign launch_s       = trig_s && cfg_complete_o;
    assign zero_dim_s     = job_has_zero_dim(unpack_job(staged_s));

    redmule_job_regfile_staging #(
        .SysDataWidth (SysDataWidth),
        .NumCfgRegs   (NumCfgRegs),
        .IdxWidth     (IdxWidth)
    ) i_staging (
        .clk         (clk_i),
        .rst         (rst_i),
        .clear       (clear_i),
        .wr_en       (stage_wr_s && periph.gnt),
        .wr_idx      (wr_idx_s),
        .wr_be       (periph.be),
        .wr_data     (periph.data),
        .mask_clr    (launch_s),
        .words       (staged_s),
        .all_written (all_written_s)
    );

    // Status readback; every other read address returns zero.
    always_comb begin
        read_data_s = '0;
        if (periph.req && periph.wen && (word_addr_s == StatusWord)) begin
            read_data_s = SysDataWidth'({err_r, state_r == PENDING, state_r != IDLE});
        end else begin
            read_data_s = '0;
        end
    end

    // Job FSM next state; zero-dimension descriptors never leave IDLE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s && !zero_dim_s) state_n = PENDING;
                else                         state_n = IDLE;
            end
            PENDING: begin
                if (job_ready_i) state_n = RUNNING;
                else             state_n = PENDING;
            end
            RUNNING: begin
                if (done_i) state_n = IDLE;
                else        state_n = RUNNING;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, descriptor, sticky error, event and registered bus response.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_r   <= IDLE;
            job_r     <= '0;
            err_r     <= 1'b0;
            evt_r     <= 1'b0;
            r_valid_r <= 1'b0;
            r_data_r  <= '0;
            r_id_r    <= '0;
        end else begin
            state_r   <= state_n;
            if (launch_s) begin
                job_r <= staged_s;
            end
            err_r     <= err_r || (trig_s && (!cfg_complete_o || zero_dim_s));
            evt_r     <= (launch_s && zero_dim_s) || ((state_r == RUNNING) && done_i);
            r_valid_r <= periph.gnt;
            if (periph.gnt) begin
                r_data_r <= read_data_s;
                r_id_r   <= periph.id;
            end
        end
    end

    assign periph.r_valid = r_valid_r;
    assign periph.r_data  = r_data_r;
    assign periph.r_id    = r_id_r;
    assign job_valid_o    = (state_r == PENDING);
    assign busy_o         = (state_r != IDLE);
    assign job_cfg_o      = job_r;
    assign evt_o          = evt_r;

endmodule

// File: tb/tb_redmule_job_regfile.sv
// Bench for redmule_job_regfile: directed scenarios plus random traffic, all outputs
// compared every cycle against a transaction-level job model.
module tb_redmule_job_regfile;
    localparam int DW = 32;
    localparam int NC = 6;

    logic clk = 1'b0, rst = 1'b0, clear = 1'b0, job_ready = 1'b0, done = 1'b0;
    logic cfg_complete, job_valid, evt, busy;
    logic [NC*DW-1:0] job_cfg;

    redmule_job_regfile_if #(.AddrWidth(32), .SysDataWidth(DW), .IdWidth(1)) bus ();

    redmule_job_regfile dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .periph         (bus),
        .cfg_complete_o (cfg_complete),
        .job_valid_o    (job_valid),
        .job_ready_i    (job_ready),
        .job_cfg_o      (job_cfg),
        .done_i         (done),
        .evt_o          (evt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model: job phase 0=idle 1=waiting for engine 2=engine working
    int          m_phase;
    logic [31:0] m_stage [NC];
    bit          m_written [NC];
    logic [31:0] m_job [NC];
    bit          m_err, m_evt, m_rvalid;
    logic        m_rid;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_all_written();
        for (int i = 0; i < NC; i++) if (!m_written[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_complete();
        return m_all_written() && (m_phase == 0);
    endfunction

    function automatic bit m_gnt();
        int w;
        w = int'(bus.add[31:2]);
        return bus.req && !(!bus.wen && w >= 16 && w < 16 + NC && m_phase == 1);
    endfunction

    function automatic logic [NC*DW-1:0] m_job_flat();
        logic [NC*DW-1:0] f;
        for (int i = 0; i < NC; i++) f[i*DW +: DW] = m_job[i];
        return f;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_err = 0; m_evt = 0; m_rvalid = 0; m_rid = 0; m_rdata = 0;
        for (int i = 0; i < NC; i++) begin
            m_stage[i] = 0; m_written[i] = 0; m_job[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs presented in that cycle.
    task automatic model_step();
        bit g, comp, ev;
        int w, old;
        if (rst || clear) begin
            model_reset();
            return;
        end
        g = m_gnt(); comp = m_complete(); ev = 0;
        w = int'(bus.add[31:2]); old = m_phase;
        m_rvalid = g;
        if (g) begin
            m_rid   = bus.id;
            m_rdata = (bus.wen && w == 1) ? {29'd0, m_err, old == 1, old != 0} : 32'd0;
        end
        if (g && !bus.wen) begin
            if (w == 0) begin
                if (comp) begin
                    for (int i = 0; i < NC; i++) begin
                        m_job[i] = m_stage[i]; m_written[i] = 0;
                    end
                    if (m_stage[3][15:0] == 0 || m_stage[3][31:16] == 0 || m_stage[4] == 0) begin
                        m_err = 1; ev = 1;
                    end else begin
                        m_phase = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end else if (w >= 16 && w < 16 + NC) begin
                for (int b = 0; b < 4; b++)
                    if (bus.be[b]) m_stage[w-16][b*8 +: 8] = bus.data[b*8 +: 8];
                m_written[w-16] = 1;
            end
        end
        if (old == 1 && job_ready) m_phase = 2;
        if (old == 2 && done) begin
            m_phase = 0; ev = 1;
        end
        m_evt = ev;
    endtask

    // Single compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("gnt", bus.gnt, m_gnt());
            check("cfg_complete", cfg_complete, m_complete());
            check("job_valid", job_valid, m_phase == 1);
            check("busy", busy, m_phase != 0);
            check("evt", evt, m_evt);
            check("r_valid", bus.r_valid, m_rvalid);
            if (m_rvalid) begin
                check("r_data", bus.r_data, m_rdata);
                check("r_id", bus.r_id, m_rid);
            end
            check("job_cfg", job_cfg, m_job_flat());
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_idle();
        bus.req = 0; bus.wen = 1; bus.add = 0; bus.be = 0; bus.data = 0; bus.id = 0;
    endtask

    task automatic bus_op(input logic wen, input logic [31:0] addr, input logic [31:0] data);
        bus.req = 1; bus.wen = wen; bus.add = addr; bus.be = 4'hf; bus.data = data;
        bus.id = 1'($urandom_range(0, 1));
        #1;
        for (int k = 0; k < 64 && !m_gnt(); k++) tick();
        if (!m_gnt()) begin
            n_checks++; n_fail++;
            $display("FAIL bus_timeout: addr %0h never granted", addr);
        end
        tick();
        bus_idle();
    endtask

    task automatic write_job(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5);
        logic [31:0] w [NC];
        w = '{w0, w1, w2, w3, w4, w5};
        for (int i = 0; i < NC; i++) bus_op(1'b0, 32'h40 + 32'(4*i), w[i]);
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        bus_idle();
        model_reset();
        rst = 1;
        tick();
        cmp_en = 1;
        tick();
        rst = 0;
        check("rst_busy", busy, 1'b0);
        check("rst_job_cfg", job_cfg, 192'd0);
        check("rst_cfg_complete", cfg_complete, 1'b0);

        // Reference job and trigger
        write_job(32'h1000, 32'h2000, 32'h3000, 32'h0020_0010, 32'h8, 32'h480);
        check("a_cfg_complete", cfg_complete, 1'b1);
        bus_op(1'b0, 32'h0, 32'h0);
        check("a_job_valid", job_valid, 1'b1);
        check("a_m", job_cfg[96 +: 16], 16'd16);
        check("a_k", job_cfg[112 +: 16], 16'd32);
        check("a_n", job_cfg[128 +: 32], 32'd8);
        check("a_x", job_cfg[0 +: 32], 32'h1000);

        // Engine not ready: staging write stalls until the handshake
        repeat (5) tick();
        check("hold_job_valid", job_valid, 1'b1);
        bus.req = 1; bus.wen = 0; bus.add = 32'h40; bus.be = 4'hf; bus.data = 32'h1111; bus.id = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_gnt", bus.gnt, 1'b0);
            tick();
        end
        job_ready = 1; #1;
        check("stall_gnt_ready", bus.gnt, 1'b0);
        tick();
        job_ready = 0;
        check("gnt_after_ready", bus.gnt, 1'b1);
        tick();
        bus_idle();

        // Stage the next job while the engine runs, then finish
        for (int i = 1; i < NC; i++)
            bus_op(1'b0, 32'h40 + 32'(4*i), (i == 3) ? 32'h0004_0004 : 32'h5000 + 32'(i));
        check("run_cfg_complete", cfg_complete, 1'b0);
        done = 1; tick(); done = 0;
        check("done_evt", evt, 1'b1);
        check("done_cfg_complete", cfg_complete, 1'b1);
        tick();
        check("evt_single", evt, 1'b0);

        // Run the staged job through
        bus_op(1'b0, 32'h0, 32'h0);
        check("b_x", job_cfg[0 +: 32], 32'h1111);
        job_ready = 1; tick(); job_ready = 0;
        done = 1; tick(); done = 0;
        tick();

        // Trigger with only five words staged
        for (int i = 0; i < 5; i++) bus_op(1'b0, 32'h40 + 32'(4*i), 32'h77 + 32'(i));
        bus.req = 1; bus.wen = 0; bus.add = 32'h2; bus.be = 4'hf; bus.data = 0; #1;
        check("incomplete_gnt", bus.gnt, 1'b1);
        tick();
        bus_idle();
        check("incomplete_no_valid", job_valid, 1'b0);
        bus_op(1'b1, 32'h4, 32'h0);
        check("status_err", bus.r_data, 32'h4);

        // Zero-N descriptor is dropped with an event
        do_reset();
        write_job(32'h10, 32'h20, 32'h30, 32'h0001_0001, 32'h0, 32'h0);
        bus_op(1'b0, 32'h0, 32'h0);
        check("zero_n_no_valid", job_valid, 1'b0);
        check("zero_n_evt", evt, 1'b1);
        bus_op(1'b1, 32'h4, 32'h0);
        check("zero_n_status", bus.r_data, 32'h4);

        // Reset while running drops the job silently
        do_reset();
        write_job(32'h1000, 32'h2000, 32'h3000, 32'h0020_0010, 32'h8, 32'h480);
        bus_op(1'b0, 32'h0, 32'h0);
        job_ready = 1; tick(); job_ready = 0;
        check("running_busy", busy, 1'b1);
        rst = 1; tick(); rst = 0;
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_job_cfg", job_cfg, 192'd0);
        check("rst_run_r_valid", bus.r_valid, 1'b0);
        done = 1; tick(); done = 0;
        check("rst_run_no_evt", evt, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            clear     = ($urandom_range(0, 199) == 0);
            job_ready = 1'($urandom_range(0, 1));
            done      = ($urandom_range(0, 7) == 0);
            bus.req   = ($urandom_range(0, 3) != 0);
            bus.wen   = ($urandom_range(0, 4) == 0);
            sel       = $urandom_range(0, 9);
            case (sel)
                6:       bus.add = 32'h0;
                7:       bus.add = 32'h4;
                8:       bus.add = 32'h80;
                9:       bus.add = 32'h3C;
                default: bus.add = 32'h40 + 32'(4*sel);
            endcase
            bus.add[1:0] = 2'($urandom_range(0, 3));
            bus.be   = 4'($urandom);
            bus.data = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            bus.id   = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 0; clear = 0; done = 0; job_ready = 0;
        bus_idle();
        tick();
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
